// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instruction and register data into EX,
// inserts load-use / flush bubbles, forwards EX operands from MEM/WB, counts hazards.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_imm,
  input  logic [4:0]        id_dest,
  input  logic              id_regwr,
  input  logic              id_memrd,
  input  logic              id_memwr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              mem_regwr,
  input  logic [4:0]        mem_dest,
  input  logic [31:0]       mem_data,
  input  logic              wb_regwr,
  input  logic [4:0]        wb_dest,
  input  logic [31:0]       wb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic              ex_regwr,
  output logic              ex_memrd,
  output logic              ex_memwr,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_op_a,
  output logic [31:0]       ex_op_b,
  output logic [CNT_W-1:0]  load_use_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        load_use;

  always_comb begin
    load_use = id_valid && ex_valid && ex_memrd && ex_regwr && (ex_dest != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));
    id_ready = !ex_stall && (flush || !load_use);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_regwr     <= 1'b0;
      ex_memrd     <= 1'b0;
      ex_memwr     <= 1'b0;
      ex_pc        <= '0;
      ex_imm       <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dest      <= '0;
      ex_ctrl      <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else if (!ex_stall) begin
      if (flush || load_use) begin
        ex_valid   <= 1'b0;
        ex_regwr   <= 1'b0;
        ex_memrd   <= 1'b0;
        ex_memwr   <= 1'b0;
        ex_pc      <= '0;
        ex_imm     <= '0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_dest    <= '0;
        ex_ctrl    <= '0;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
      end else begin
        // side-effect bits are qualified so a non-valid slot can never write state
        ex_valid   <= id_valid;
        ex_regwr   <= id_regwr & id_valid;
        ex_memrd   <= id_memrd & id_valid;
        ex_memwr   <= id_memwr & id_valid;
        ex_pc      <= id_pc;
        ex_imm     <= id_imm;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_dest    <= id_dest;
        ex_ctrl    <= id_ctrl;
        ex_rs_data <= id_rs_data;
        ex_rt_data <= id_rt_data;
      end
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (load_use && !flush && (load_use_cnt != '1))
        load_use_cnt <= load_use_cnt + CNT_W'(1);
    end
  end

  // MEM result is younger than WB, so it wins; $0 is hard-wired and never forwarded
  always_comb begin
    ex_op_a = ex_rs_data;
    if (mem_regwr && (mem_dest != 5'd0) && (mem_dest == ex_rs))
      ex_op_a = mem_data;
    else if (wb_regwr && (wb_dest != 5'd0) && (wb_dest == ex_rs))
      ex_op_a = wb_data;

    ex_op_b = ex_rt_data;
    if (mem_regwr && (mem_dest != 5'd0) && (mem_dest == ex_rt))
      ex_op_b = mem_data;
    else if (wb_regwr && (wb_dest != 5'd0) && (wb_dest == ex_rt))
      ex_op_b = wb_data;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX state is queued when ID is driven
// and compared one edge later; combinational outputs are checked directly.
module tb_id_ex_stage;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_uses_rs, id_uses_rt, id_regwr, id_memrd, id_memwr;
  logic [31:0]       id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]        id_rs, id_rt, id_dest;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush, ex_stall;
  logic              mem_regwr, wb_regwr;
  logic [4:0]        mem_dest, wb_dest;
  logic [31:0]       mem_data, wb_data;
  logic              id_ready, ex_valid, ex_regwr, ex_memrd, ex_memwr;
  logic [31:0]       ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [4:0]        ex_rs, ex_rt, ex_dest;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  load_use_cnt, flush_cnt;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_dest(id_dest), .id_regwr(id_regwr), .id_memrd(id_memrd), .id_memwr(id_memwr),
    .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall),
    .mem_regwr(mem_regwr), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_regwr(wb_regwr), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_regwr(ex_regwr),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid, regwr, memrd, memwr;
    logic [31:0]       pc, imm, rs_data, rt_data;
    logic [4:0]        rs, rt, dest;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0]  lu, fl;
  } exp_t;

  exp_t             sb[$];
  exp_t             cur;
  int unsigned      n_cmp = 0;
  int unsigned      n_bad = 0;
  logic [CNT_W-1:0] lu_exp = '0;
  logic [CNT_W-1:0] fl_exp = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic exp_t mk_bubble();
    exp_t e;
    e.valid = 0; e.regwr = 0; e.memrd = 0; e.memwr = 0;
    e.pc = '0; e.imm = '0; e.rs_data = '0; e.rt_data = '0;
    e.rs = '0; e.rt = '0; e.dest = '0; e.ctrl = '0;
    e.lu = lu_exp; e.fl = fl_exp;
    return e;
  endfunction

  function automatic exp_t mk_capture();
    exp_t e;
    e.valid = id_valid;
    e.regwr = id_regwr & id_valid;
    e.memrd = id_memrd & id_valid;
    e.memwr = id_memwr & id_valid;
    e.pc = id_pc; e.imm = id_imm; e.rs_data = id_rs_data; e.rt_data = id_rt_data;
    e.rs = id_rs; e.rt = id_rt; e.dest = id_dest; e.ctrl = id_ctrl;
    e.lu = lu_exp; e.fl = fl_exp;
    return e;
  endfunction

  task automatic push(input exp_t e);
    cur = e;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    check("ex_valid", ex_valid, e.valid);
    check("ex_regwr", ex_regwr, e.regwr);
    check("ex_memrd", ex_memrd, e.memrd);
    check("ex_memwr", ex_memwr, e.memwr);
    check("ex_pc", ex_pc, e.pc);
    check("ex_imm", ex_imm, e.imm);
    check("ex_rs", ex_rs, e.rs);
    check("ex_rt", ex_rt, e.rt);
    check("ex_dest", ex_dest, e.dest);
    check("ex_ctrl", ex_ctrl, e.ctrl);
    check("load_use_cnt", load_use_cnt, e.lu);
    check("flush_cnt", flush_cnt, e.fl);
  endtask

  // advance one edge and compare against the oldest queued expectation
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [4:0] dst, input logic rw, input logic mr,
                        input logic mw, input logic [CTRL_W-1:0] c);
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = pc ^ 32'h0000_5A5A; id_dest = dst;
    id_regwr = rw; id_memrd = mr; id_memwr = mw; id_ctrl = c;
  endtask

  task automatic fwd_off();
    mem_regwr = 0; mem_dest = '0; mem_data = '0;
    wb_regwr = 0; wb_dest = '0; wb_data = '0;
  endtask

  initial begin
    reset = 1'b0; flush = 0; ex_stall = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    fwd_off();
    #2;
    compare(mk_bubble());
    check("rst_id_ready", id_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_op_a", ex_op_a, 0);

    // addu $3,$1,$2
    set_id(1, 32'h100, 1, 2, 1, 1, 5, 7, 3, 1, 0, 0, 16'h1234);
    push(mk_capture());
    tick();
    check("addu_op_a", ex_op_a, 5);
    check("addu_op_b", ex_op_b, 7);

    // lw $4 then dependent add: one bubble, ID held
    set_id(1, 32'h104, 1, 0, 1, 0, 32'h40, 0, 4, 1, 1, 0, 16'h0001);
    push(mk_capture());
    tick();
    set_id(1, 32'h108, 4, 2, 1, 1, 32'h44, 32'h22, 5, 1, 0, 0, 16'h0002);
    #1;
    check("lu_id_ready", id_ready, 0);
    lu_exp = sat_inc(lu_exp);
    push(mk_bubble());
    tick();
    check("after_bubble_ready", id_ready, 1);
    push(mk_capture());
    tick();
    check("lu_op_a", ex_op_a, 32'h44);

    // load to $0 never stalls
    set_id(1, 32'h10C, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 16'h0003);
    push(mk_capture());
    tick();
    set_id(1, 32'h110, 0, 2, 1, 1, 0, 9, 6, 1, 0, 0, 16'h0004);
    #1;
    check("dest0_ready", id_ready, 1);
    push(mk_capture());
    tick();

    // load $4, consumer names $4 in rs but does not read it
    set_id(1, 32'h114, 1, 0, 1, 0, 0, 0, 4, 1, 1, 0, 16'h0005);
    push(mk_capture());
    tick();
    set_id(1, 32'h118, 4, 2, 0, 1, 0, 3, 7, 1, 0, 0, 16'h0006);
    #1;
    check("nouse_ready", id_ready, 1);
    push(mk_capture());
    tick();

    // invalid ID slot: side-effect bits forced low, other fields captured
    set_id(0, 32'h11C, 3, 4, 1, 1, 1, 2, 9, 1, 1, 1, 16'hBEEF);
    push(mk_capture());
    tick();

    // forwarding priority on ex_rs=$5 / ex_rt=$6
    set_id(1, 32'h120, 5, 6, 1, 1, 32'h11, 32'h22, 7, 1, 0, 0, 16'h0007);
    push(mk_capture());
    tick();
    mem_regwr = 1; mem_dest = 5; mem_data = 32'hAA;
    wb_regwr = 1; wb_dest = 5; wb_data = 32'hBB;
    #1;
    check("fwd_mem_a", ex_op_a, 32'hAA);
    check("fwd_none_b", ex_op_b, 32'h22);
    mem_regwr = 0;
    #1;
    check("fwd_wb_a", ex_op_a, 32'hBB);
    mem_regwr = 1; mem_dest = 0;
    #1;
    check("fwd_mem0_a", ex_op_a, 32'hBB);
    wb_dest = 6;
    #1;
    check("fwd_wb_b", ex_op_b, 32'hBB);
    check("fwd_stored_a", ex_op_a, 32'h11);
    fwd_off();

    // flush overriding a load-use
    set_id(1, 32'h124, 1, 0, 1, 0, 0, 0, 4, 1, 1, 0, 16'h0008);
    push(mk_capture());
    tick();
    set_id(1, 32'h128, 4, 0, 1, 0, 0, 0, 8, 1, 0, 0, 16'h0009);
    flush = 1;
    #1;
    check("flush_lu_ready", id_ready, 1);
    fl_exp = sat_inc(fl_exp);
    push(mk_bubble());
    tick();
    flush = 0;

    // stall holds EX with flush asserted and changing ID data
    set_id(1, 32'h130, 9, 10, 1, 1, 32'h99, 32'hA0, 11, 1, 0, 1, 16'h000A);
    push(mk_capture());
    tick();
    ex_stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h200 + 32'(i), 1, 2, 1, 1, 1, 2, 3, 1, 0, 0, 16'hF000);
      #1;
      check("stall_ready", id_ready, 0);
      push(cur);
      tick();
    end
    mem_regwr = 1; mem_dest = 9; mem_data = 32'hCC;
    #1;
    check("stall_fwd_a", ex_op_a, 32'hCC);
    fwd_off();
    ex_stall = 0;

    // repeated flushes saturate the counter
    for (int i = 0; i < 18; i++) begin
      fl_exp = sat_inc(fl_exp);
      push(mk_bubble());
      tick();
    end
    check("flush_sat", flush_cnt, 4'hF);
    flush = 0;

    // mid-cycle async reset clears EX before the next edge
    set_id(1, 32'h300, 1, 2, 1, 1, 3, 4, 5, 1, 0, 0, 16'h0BAD);
    push(mk_capture());
    tick();
    #2;
    reset = 1'b0;
    #1;
    lu_exp = '0; fl_exp = '0;
    compare(mk_bubble());
    #1;
    reset = 1'b1;
    push(mk_capture());
    tick();

    if (sb.size() != 0) check("scoreboard_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage core, directly downstream of the register file.
- Registers the decoded instruction and register-file read data into EX.
- Detects load-use hazards and inserts bubbles; handles branch flush and downstream stall.
- Provides EX-stage operand forwarding from MEM and WB, plus saturating hazard counters.

Parameters:
CTRL_W, 16, width of opaque EX/MEM/WB control bundle passed through
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
id_valid  in  1  ID holds a real instruction
id_pc  in  32  PC of ID instruction
id_rs, id_rt  in  5  source register numbers (register-file read addresses)
id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
id_rs_data, id_rt_data  in  32  register-file read data (already WB-bypassed)
id_imm  in  32  extended immediate
id_dest  in  5  destination register
id_regwr, id_memrd, id_memwr  in  1  register write / load / store
id_ctrl  in  CTRL_W  remaining control bits
flush  in  1  EX branch/jump taken: kill ID instruction
ex_stall  in  1  downstream stall: freeze EX
mem_regwr  in  1; mem_dest  in  5; mem_data  in  32  EX/MEM forwarding source
wb_regwr  in  1; wb_dest  in  5; wb_data  in  32  MEM/WB forwarding source
id_ready  out  1  ID instruction accepted this cycle; upstream advances IF/ID only when 1
ex_valid, ex_regwr, ex_memrd, ex_memwr  out  1  registered
ex_pc, ex_imm  out  32  registered
ex_rs, ex_rt, ex_dest  out  5  registered
ex_ctrl  out  CTRL_W  registered
ex_op_a, ex_op_b  out  32  forwarded operands (combinational)
load_use_cnt, flush_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (reset=0, async): every registered ex_* field and both counters = 0. EX holds a bubble, so id_ready = !ex_stall.
- load_use (combinational), asserted when all hold:
  - id_valid, ex_valid, ex_memrd, ex_regwr, ex_dest != 0;
  - (id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest).
- id_ready = !ex_stall && (flush || !load_use).
- Per-edge update priority:
  1. ex_stall=1: hold all EX registers. flush is ignored; its source re-asserts it.
  2. flush=1: load bubble.
  3. load_use=1: load bubble; ID is held because id_ready=0.
  4. Otherwise: capture all id_* fields. ex_valid = id_valid.
- Bubble: ex_valid = ex_regwr = ex_memrd = ex_memwr = 0; ex_ctrl = 0; every other field = 0.
- id_valid=0 captured normally: ex_valid=0, and ex_regwr/ex_memrd/ex_memwr are forced to 0.
- Latency: one cycle ID to EX. Load-use costs exactly one bubble. The next cycle forwards from WB, or from the register-file bypass if already written.
- Forwarding for ex_op_a (source ex_rs, stored rs data); ex_op_b is identical with ex_rt:
  - MEM match first: mem_regwr && mem_dest != 0 && mem_dest == ex_rs → mem_data;
  - else WB match: wb_regwr && wb_dest != 0 && wb_dest == ex_rs → wb_data;
  - else stored rs data.
  - MEM has priority over WB. Register 0 is never forwarded. Forwarding is also evaluated during ex_stall.
- Counters, updated only when ex_stall=0:
  - load_use_cnt increments on edges where load_use && !flush;
  - flush_cnt increments on edges where flush;
  - both saturate at all-ones with no wrap.
- Mid-operation reset clears the EX entry immediately, without waiting for a clock edge.

Test Plan:
- Reset release, idle inputs: all ex_* = 0, counters 0, id_ready=1. Then ID addu $3,$1,$2 with rs_data=5, rt_data=7 → next edge ex_dest=3, ex_op_a=5, ex_op_b=7, ex_valid=1.
- lw $4 in EX, ID add using rs=$4 → id_ready=0, next EX is a bubble, ID held, load_use_cnt=1. Same case with dest $0 or id_uses_rs=0 → no stall.
- ex_rs=$5, mem_dest=$5 (mem_data=0xAA), wb_dest=$5 (wb_data=0xBB), both regwr=1 → ex_op_a=0xAA. Drop mem_regwr → 0xBB. Set mem_dest=0 with regwr=1 → no MEM forward.
- flush with load_use also true → EX bubble, id_ready=1, flush_cnt=1, load_use_cnt unchanged.
- ex_stall=1 for 3 cycles with flush=1 and new ID data → EX fields unchanged, id_ready=0, counters unchanged.
- Counter preloaded to all-ones via repeated flushes (CNT_W=4): 16th and later flushes keep flush_cnt=4'hF. Async reset pulsed mid-cycle → outputs 0 before the next edge.
